arm_microsequencer: RTL



---
 rtl/arm_microsequencer_if.sv | 24 ++
 rtl/arm_microsequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/arm_microsequencer_if.sv
// Bundles the control-word, status and handshake signals that flow between
// the microsequencer and the rest of the microprogrammed control unit.
interface arm_microsequencer_if;
  logic [2:0] ms_sel;
  logic [6:0] cr_addr;
  logic [6:0] enc_state;
  logic       cond_true;
  logic       moc;
  logic       irq;
  logic [6:0] cs_addr;
  logic [6:0] ret_addr;
  logic       irq_ack;
  logic       mem_fault;

  modport master (
    output ms_sel, cr_addr, enc_state, cond_true, moc, irq,
    input  cs_addr, ret_addr, irq_ack, mem_fault
  );

  modport slave (
    input  ms_sel, cr_addr, enc_state, cond_true, moc, irq,
    output cs_addr, ret_addr, irq_ack, mem_fault
  );
endinterface

// File: rtl/arm_microsequencer.sv
// Next-address sequencer for the microprogrammed ARM control unit: picks the
// next control-store address from increment/jump/decode/branch/wait/call/fetch.
module arm_microsequencer #(
  parameter logic [6:0] RESET_ADDR  = 7'd0,
  parameter logic [6:0] FETCH_ADDR  = 7'd1,
  parameter logic [6:0] IRQ_ADDR    = 7'd120,
  parameter logic [6:0] FAULT_ADDR  = 7'd127,
  parameter int         MOC_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_microsequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ModeInc     = 3'd0,
    ModeJump    = 3'd1,
    ModeDecode  = 3'd2,
    ModeCbr     = 3'd3,
    ModeWaitMoc = 3'd4,
    ModeCall    = 3'd5,
    ModeRet     = 3'd6,
    ModeFetch   = 3'd7
  } msMode;

  localparam logic [7:0] WaitLast = 8'(MOC_TIMEOUT - 1);

  logic [6:0] csAddrReg, csAddrNext;
  logic [6:0] retAddrReg, retAddrNext;
  logic [7:0] waitCntReg, waitCntNext;
  logic       irqPendingReg, irqPendingNext;
  logic       irqAckReg, irqAckNext;
  logic       memFaultReg, memFaultNext;
  logic [6:0] csAddrInc;

  assign csAddrInc = csAddrReg + 7'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      csAddrReg     <= RESET_ADDR;
      retAddrReg    <= 7'd0;
      waitCntReg    <= 8'd0;
      irqPendingReg <= 1'b0;
      irqAckReg     <= 1'b0;
      memFaultReg   <= 1'b0;
    end else begin
      csAddrReg     <= csAddrNext;
      retAddrReg    <= retAddrNext;
      waitCntReg    <= waitCntNext;
      irqPendingReg <= irqPendingNext;
      irqAckReg     <= irqAckNext;
      memFaultReg   <= memFaultNext;
    end
  end

  always_comb begin
    csAddrNext     = csAddrReg;
    retAddrNext    = retAddrReg;
    waitCntNext    = 8'd0;
    irqPendingNext = irqPendingReg | bus.irq;
    irqAckNext     = 1'b0;
    memFaultNext   = memFaultReg;

    case (bus.ms_sel)
      ModeInc:    csAddrNext = csAddrInc;
      ModeJump:   csAddrNext = bus.cr_addr;
      ModeDecode: csAddrNext = bus.cond_true ? bus.enc_state : FETCH_ADDR;
      ModeCbr:    csAddrNext = bus.cond_true ? bus.cr_addr : csAddrInc;
      ModeWaitMoc: begin
        if (bus.moc) begin
          csAddrNext = csAddrInc;
        end else if (waitCntReg < WaitLast) begin
          waitCntNext = waitCntReg + 8'd1;
        end else begin
          csAddrNext   = FAULT_ADDR;
          memFaultNext = 1'b1;
        end
      end
      ModeCall: begin
        retAddrNext = csAddrInc;
        csAddrNext  = bus.cr_addr;
      end
      ModeRet:    csAddrNext = retAddrReg;
      ModeFetch: begin
        // A request arriving in the entry cycle is absorbed by this entry.
        if (irqPendingReg) begin
          csAddrNext     = IRQ_ADDR;
          irqAckNext     = 1'b1;
          irqPendingNext = 1'b0;
        end else begin
          csAddrNext = FETCH_ADDR;
        end
      end
      default: csAddrNext = csAddrReg;
    endcase
  end

  assign bus.cs_addr   = csAddrReg;
  assign bus.ret_addr  = retAddrReg;
  assign bus.irq_ack   = irqAckReg;
  assign bus.mem_fault = memFaultReg;

endmodule
